// File: rtl/axi_mon_streams_if.sv
// AXI4 read-channel (AR + R) signal bundle snooped by axi_mon_streams.
// master/slave modports describe the real bus ends; monitor only observes.
interface axi_mon_streams_if;
    logic [31:0]  ARADDR;
    logic         ARREADY;
    logic         ARVALID;
    logic [3:0]   ARID;
    logic [511:0] RDATA;
    logic         RREADY;
    logic         RLAST;
    logic         RVALID;
    logic [1:0]   RRESP;
    logic [3:0]   RID;

    modport master (
        output ARADDR, ARVALID, ARID, RREADY,
        input  ARREADY, RDATA, RLAST, RVALID, RRESP, RID
    );

    modport slave (
        input  ARADDR, ARVALID, ARID, RREADY,
        output ARREADY, RDATA, RLAST, RVALID, RRESP, RID
    );

    modport monitor (
        input ARADDR, ARREADY, ARVALID, ARID,
        input RDATA, RREADY, RLAST, RVALID, RRESP, RID
    );
endinterface

// File: rtl/axi_mon_streams.sv
// Passive multi-stream AXI4 read checker with a sticky error flag.
// Define MON_STREAMS_DATA_CHECK_EN to compile in the 512-bit data-pattern compare.
module axi_mon_streams #(
    parameter int unsigned NUM_STREAMS     = 12,
    parameter int unsigned STREAM_SIZE     = 230400,
    parameter int unsigned STREAM_ADDR_LSB = 20,
    parameter int unsigned BEAT_BYTES      = 64,
    parameter int unsigned FIFO_DEPTH      = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    axi_mon_streams_if.monitor        bus,
    output logic                      error_detect
);
    localparam int unsigned PTR_W   = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W   = PTR_W + 1;
    localparam int unsigned OFF_W   = STREAM_ADDR_LSB;
    localparam int unsigned ALIGN_W = $clog2(BEAT_BYTES);
    localparam int unsigned LANES   = BEAT_BYTES / 4;

    logic [31:0]      fifoAddr_q [FIFO_DEPTH];
    logic [3:0]       fifoId_q   [FIFO_DEPTH];
    logic [PTR_W-1:0] wrPtr_q, wrPtr_d, rdPtr_q, rdPtr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [8:0]       beatCnt_q, beatCnt_d;
    logic [OFF_W-1:0] expOff_q [NUM_STREAMS];
    logic             errorDetect_q, errorDetect_d;

    logic             arFire, rFire, fifoEmpty, fifoFull;
    logic             beatValid, push, pop, dropErr, beatErr, burstErr, dataErr;
    logic [31:0]      headAddr;
    logic [3:0]       headId;
    logic [3:0]       streamIdx, streamSel;
    logic             streamOk;
    logic [OFF_W-1:0] offset, newOff;
    logic [31:0]      burstBytes, burstEnd;

    always_comb begin
        arFire    = bus.ARVALID & bus.ARREADY;
        rFire     = bus.RVALID & bus.RREADY;
        fifoEmpty = (count_q == '0);
        fifoFull  = (count_q == CNT_W'(FIFO_DEPTH));
        headAddr  = fifoAddr_q[rdPtr_q];
        headId    = fifoId_q[rdPtr_q];
        beatValid = rFire & ~fifoEmpty;
        pop       = beatValid & bus.RLAST;
        // A full FIFO can still accept a push when the head retires in the same cycle.
        push      = arFire & (~fifoFull | pop);
        dropErr   = arFire & fifoFull & ~pop;
    end

`ifdef MON_STREAMS_DATA_CHECK_EN
    logic [31:0] beatAddr;

    always_comb begin
        dataErr  = 1'b0;
        beatAddr = headAddr + 32'(beatCnt_q) * 32'(BEAT_BYTES);
        for (int j = 0; j < int'(LANES); j++) begin
            if (bus.RDATA[32*j +: 32] != beatAddr + 32'(4 * j)) begin
                dataErr = 1'b1;
            end
        end
    end
`else
    assign dataErr = 1'b0;
`endif

    always_comb begin
        beatErr = 1'b0;
        if (rFire) begin
            beatErr = fifoEmpty | (bus.RID != headId) | (bus.RRESP != 2'b00) | dataErr;
        end
    end

    // Burst-level checks evaluated on the retiring head entry at RLAST.
    always_comb begin
        streamIdx  = headAddr[STREAM_ADDR_LSB+3 -: 4];
        offset     = headAddr[OFF_W-1:0];
        streamOk   = (32'(streamIdx) < NUM_STREAMS);
        streamSel  = streamOk ? streamIdx : 4'd0;
        burstBytes = 32'(beatCnt_q + 9'd1) * 32'(BEAT_BYTES);
        burstEnd   = 32'(offset) + burstBytes;
        newOff     = (burstEnd == STREAM_SIZE) ? '0 : burstEnd[OFF_W-1:0];
        burstErr   = 1'b0;
        if (pop) begin
            burstErr = ~streamOk
                     | (offset[ALIGN_W-1:0] != '0)
                     | (offset != expOff_q[streamSel])
                     | (burstEnd > STREAM_SIZE);
        end
    end

    always_comb begin
        wrPtr_d       = push ? wrPtr_q + PTR_W'(1) : wrPtr_q;
        rdPtr_d       = pop ? rdPtr_q + PTR_W'(1) : rdPtr_q;
        count_d       = count_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        beatCnt_d     = beatCnt_q;
        if (rFire && bus.RLAST) begin
            beatCnt_d = '0;
        end else if (beatValid) begin
            beatCnt_d = beatCnt_q + 9'd1;
        end
        errorDetect_d = errorDetect_q | beatErr | burstErr | dropErr;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wrPtr_q       <= '0;
            rdPtr_q       <= '0;
            count_q       <= '0;
            beatCnt_q     <= '0;
            errorDetect_q <= 1'b0;
            for (int i = 0; i < int'(NUM_STREAMS); i++) begin
                expOff_q[i] <= '0;
            end
        end else begin
            wrPtr_q       <= wrPtr_d;
            rdPtr_q       <= rdPtr_d;
            count_q       <= count_d;
            beatCnt_q     <= beatCnt_d;
            errorDetect_q <= errorDetect_d;
            if (pop && streamOk) begin
                expOff_q[streamSel] <= newOff;
            end
        end
    end

    // Entry storage needs no reset; validity is tracked by the pointers and count.
    always_ff @(posedge clk) begin
        if (push) begin
            fifoAddr_q[wrPtr_q] <= bus.ARADDR;
            fifoId_q[wrPtr_q]   <= bus.ARID;
        end
    end

    assign error_detect = errorDetect_q;
endmodule

// File: tb/tb_axi_mon_streams.sv
// Directed self-checking bench for axi_mon_streams.
// Lane-corruption expectation follows MON_STREAMS_DATA_CHECK_EN.
module tb_axi_mon_streams;
`ifdef MON_STREAMS_DATA_CHECK_EN
    localparam logic DATA_EXP = 1'b1;
`else
    localparam logic DATA_EXP = 1'b0;
`endif

    logic clk;
    logic reset;
    logic errorDetect;
    int   compareCount;
    int   failCount;
    int   off [12];
    logic [31:0] pendAddr [4];
    int          pendLen  [4];
    logic [3:0]  pendId   [4];

    axi_mon_streams_if bus();

    axi_mon_streams dut (
        .clk          (clk),
        .reset        (reset),
        .bus          (bus),
        .error_detect (errorDetect)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [511:0] beatData(input logic [31:0] addr);
        logic [511:0] d;
        for (int j = 0; j < 16; j++) begin
            d[32*j +: 32] = addr + 32'(4 * j);
        end
        return d;
    endfunction

    // Drives one bus cycle starting at a negedge, then returns at the next negedge.
    task automatic applyStimulus(input logic arV, input logic [31:0] arAddr, input logic [3:0] arId,
                                 input logic rV, input logic [31:0] rAddr, input logic [3:0] rId,
                                 input logic rLast, input logic [1:0] rResp, input logic flipLane5);
        logic [511:0] d;
        d = beatData(rAddr);
        if (flipLane5) d[160] = ~d[160];
        bus.ARVALID = arV;
        bus.ARADDR  = arAddr;
        bus.ARID    = arId;
        bus.RVALID  = rV;
        bus.RDATA   = d;
        bus.RID     = rId;
        bus.RLAST   = rLast;
        bus.RRESP   = rResp;
        @(negedge clk);
        bus.ARVALID = 1'b0;
        bus.RVALID  = 1'b0;
        bus.RLAST   = 1'b0;
    endtask

    task automatic checkOutput(input string tag, input logic expected);
        compareCount++;
        assert (errorDetect === expected) else begin
            failCount++;
            $error("[TB] FAIL %s: observed %b expected %b", tag, errorDetect, expected);
        end
    endtask

    task automatic idle();
        applyStimulus(1'b0, 32'h0, 4'h0, 1'b0, 32'h0, 4'h0, 1'b0, 2'b00, 1'b0);
    endtask

    task automatic doReset();
        reset = 1'b1;
        idle();
        reset = 1'b0;
    endtask

    task automatic sendAr(input logic [31:0] addr, input logic [3:0] id);
        applyStimulus(1'b1, addr, id, 1'b0, 32'h0, 4'h0, 1'b0, 2'b00, 1'b0);
    endtask

    task automatic sendBeat(input logic [31:0] addr, input logic [3:0] id, input logic last);
        applyStimulus(1'b0, 32'h0, 4'h0, 1'b1, addr, id, last, 2'b00, 1'b0);
    endtask

    task automatic sendBurst(input logic [31:0] addr, input int beats, input logic [3:0] id);
        for (int b = 0; b < beats; b++) begin
            sendBeat(addr + 32'(b * 64), id, b == beats - 1);
        end
    endtask

    initial begin
        compareCount = 0;
        failCount    = 0;
        reset        = 1'b1;
        bus.ARVALID  = 1'b0;
        bus.ARREADY  = 1'b1;
        bus.ARADDR   = '0;
        bus.ARID     = '0;
        bus.RVALID   = 1'b0;
        bus.RREADY   = 1'b1;
        bus.RDATA    = '0;
        bus.RID      = '0;
        bus.RLAST    = 1'b0;
        bus.RRESP    = 2'b00;
        @(negedge clk);
        doReset();
        checkOutput("resetState", 1'b0);

        // Stream 0 full sweep ending exactly at 0x38400, then wrap back to 0.
        sendAr(32'h0, 4'h0);
        sendBurst(32'h0, 4, 4'h0);
        for (int k = 0; k < 179; k++) begin
            sendAr(32'h100 + 32'(k) * 32'h500, 4'h0);
            sendBurst(32'h100 + 32'(k) * 32'h500, 20, 4'h0);
        end
        checkOutput("sweepBody", 1'b0);
        sendAr(32'h38000, 4'h1);
        sendBurst(32'h38000, 16, 4'h1);
        checkOutput("sweepEnd", 1'b0);
        sendAr(32'h0, 4'h2);
        sendBurst(32'h0, 20, 4'h2);
        checkOutput("sweepWrap", 1'b0);

        // Round-robin streams with 4 outstanding ARs and mixed burst lengths.
        doReset();
        for (int s = 0; s < 12; s++) off[s] = 0;
        for (int g = 0; g < 9; g++) begin
            for (int i = 0; i < 4; i++) begin
                int idx;
                int s;
                idx = g * 4 + i;
                s   = idx % 12;
                pendLen[i]  = (idx % 3 == 0) ? 20 : ((idx % 3 == 1) ? 4 : 16);
                pendAddr[i] = (32'(s) << 20) + 32'(off[s]);
                pendId[i]   = 4'(idx);
                off[s]      = off[s] + pendLen[i] * 64;
                sendAr(pendAddr[i], pendId[i]);
            end
            for (int i = 0; i < 4; i++) begin
                sendBurst(pendAddr[i], pendLen[i], pendId[i]);
            end
        end
        checkOutput("roundRobin", 1'b0);

        // Overflow: 17th AR with no pop is dropped and flagged.
        doReset();
        for (int k = 0; k < 16; k++) sendAr(32'h0010_0000 + 32'(k * 64), 4'(k));
        checkOutput("fill16", 1'b0);
        sendAr(32'h0010_0400, 4'h0);
        checkOutput("overflow", 1'b1);

        // Full FIFO with same-cycle push and pop is legal.
        doReset();
        for (int k = 0; k < 16; k++) sendAr(32'h0010_0000 + 32'(k * 64), 4'(k));
        applyStimulus(1'b1, 32'h0010_0400, 4'h0, 1'b1, 32'h0010_0000, 4'h0, 1'b1, 2'b00, 1'b0);
        for (int k = 1; k < 17; k++) sendBurst(32'h0010_0000 + 32'(k * 64), 1, 4'(k));
        checkOutput("fullPushPop", 1'b0);

        // Lane 5 corruption on beat 1 of a 4-beat burst.
        doReset();
        sendAr(32'h0020_0000, 4'h5);
        sendBeat(32'h0020_0000, 4'h5, 1'b0);
        checkOutput("lane5Before", 1'b0);
        applyStimulus(1'b0, 32'h0, 4'h0, 1'b1, 32'h0020_0040, 4'h5, 1'b0, 2'b00, 1'b1);
        checkOutput("lane5", DATA_EXP);
        sendBeat(32'h0020_0080, 4'h5, 1'b0);
        sendBeat(32'h0020_00C0, 4'h5, 1'b1);
        idle();
        checkOutput("lane5Sticky", DATA_EXP);

        doReset();
        checkOutput("clearAfterLane5", 1'b0);
        sendAr(32'h0030_0000, 4'h2);
        applyStimulus(1'b0, 32'h0, 4'h0, 1'b1, 32'h0030_0000, 4'h2, 1'b1, 2'b10, 1'b0);
        checkOutput("rrespSlvErr", 1'b1);

        doReset();
        sendAr(32'h0030_0000, 4'h0);
        sendBeat(32'h0030_0000, 4'h1, 1'b1);
        checkOutput("ridMismatch", 1'b1);

        // Stream 2 skips from 0xA00 to 0xF00; flagged only at that burst's RLAST.
        doReset();
        sendAr(32'h0020_0000, 4'h0);
        sendBurst(32'h0020_0000, 20, 4'h0);
        sendAr(32'h0020_0500, 4'h0);
        sendBurst(32'h0020_0500, 20, 4'h0);
        checkOutput("skipPre", 1'b0);
        sendAr(32'h0020_0F00, 4'h0);
        for (int b = 0; b < 19; b++) sendBeat(32'h0020_0F00 + 32'(b * 64), 4'h0, 1'b0);
        checkOutput("skipMid", 1'b0);
        sendBeat(32'h0020_0F00 + 32'(19 * 64), 4'h0, 1'b1);
        checkOutput("skipLast", 1'b1);

        doReset();
        sendAr(32'h00C0_0000, 4'h0);
        sendBeat(32'h00C0_0000, 4'h0, 1'b0);
        checkOutput("stream12Mid", 1'b0);
        sendBeat(32'h00C0_0040, 4'h0, 1'b1);
        checkOutput("stream12Last", 1'b1);

        doReset();
        sendAr(32'h0050_0020, 4'h0);
        sendBeat(32'h0050_0020, 4'h0, 1'b1);
        checkOutput("misaligned", 1'b1);

        // Orphan beat, reset clears the flag, then clean traffic stays clean.
        doReset();
        checkOutput("preOrphan", 1'b0);
        sendBeat(32'h0, 4'h0, 1'b1);
        checkOutput("orphanBeat", 1'b1);
        doReset();
        checkOutput("orphanReset", 1'b0);
        sendAr(32'h0030_0000, 4'h3);
        sendBurst(32'h0030_0000, 4, 4'h3);
        checkOutput("postResetClean", 1'b0);

        // AR and R in the same cycle with an empty FIFO: no bypass.
        doReset();
        applyStimulus(1'b1, 32'h0040_0000, 4'h0, 1'b1, 32'h0040_0000, 4'h0, 1'b0, 2'b00, 1'b0);
        checkOutput("noBypass", 1'b1);

        // Reset mid-burst abandons the outstanding entry.
        doReset();
        sendAr(32'h0060_0000, 4'h0);
        sendBeat(32'h0060_0000, 4'h0, 1'b0);
        sendBeat(32'h0060_0040, 4'h0, 1'b0);
        checkOutput("midBurst", 1'b0);
        doReset();
        checkOutput("midBurstReset", 1'b0);
        sendBeat(32'h0060_0080, 4'h0, 1'b1);
        checkOutput("abandonedBeat", 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
        $finish;
    end
endmodule
